// File: rtl/pipe_ctrl_n.sv
// Pipeline stall/flush controller for the tinyMIPS family. It builds the per-stage
// stall vector, redirects the PC on exceptions or a stall-watchdog timeout, and counts stalls and flushes.
module pipe_ctrl_n #(
    parameter int unsigned     NSTAGE    = 6,
    parameter int unsigned     AW        = 32,
    parameter logic [AW-1:0]   IBASE     = AW'(32'h0000_0020),
    parameter logic [AW-1:0]   EBASE     = AW'(32'h0000_0040),
    parameter int unsigned     FLUSH_CYC = 1,
    parameter int unsigned     WDOG_LIM  = 255,
    parameter int unsigned     CNTW      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NSTAGE-1:0] stallreq_i,
    input  logic [31:0]       excepttype_i,
    input  logic [AW-1:0]     cp0_epc_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic              flush_o,
    output logic [AW-1:0]     new_pc_o,
    output logic [31:0]       exc_code_o,
    output logic              timeout_o,
    output logic [CNTW-1:0]   stall_cnt_o,
    output logic [CNTW-1:0]   flush_cnt_o
);

    localparam logic [31:0] TIMEOUT_CODE = 32'h0000_0010;
    localparam int unsigned WDW = (WDOG_LIM > 0) ? $clog2(WDOG_LIM + 1) : 1;
    localparam int unsigned FCW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [FCW-1:0]    fcnt_q, fcnt_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [31:0]       exc_code_q, exc_code_d;
    logic              timeout_q, timeout_d;
    logic [WDW-1:0]    wd_cnt_q, wd_cnt_d;
    logic [CNTW-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNTW-1:0]   flush_cnt_q, flush_cnt_d;

    logic [NSTAGE-1:0] therm;
    logic [NSTAGE-1:0] stall;
    logic              flush;
    logic [AW-1:0]     new_pc;
    logic              ext_exc;
    logic              wd_fire;
    logic [31:0]       code;

    // Codes 0x08/0x0a/0x0c/0x0d, the internal timeout and all unlisted codes share EBASE.
    function automatic logic [AW-1:0] exc_target(input logic [31:0] c, input logic [AW-1:0] epc);
        case (c)
            32'h0000_0001: return IBASE;
            32'h0000_000e: return epc;
            default:       return EBASE;
        endcase
    endfunction

    // Thermometer fill: every stage at or below the highest requester stalls.
    always_comb begin
        logic acc;
        acc   = 1'b0;
        therm = '0;
        for (int i = NSTAGE - 1; i >= 0; i--) begin
            acc      = acc | stallreq_i[i];
            therm[i] = acc;
        end
    end

    // NOTE: every signal gets a default before the case so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pc_d        = pc_q;
        exc_code_d  = exc_code_q;
        timeout_d   = 1'b0;
        wd_cnt_d    = wd_cnt_q;
        flush_cnt_d = flush_cnt_q;
        stall       = '0;
        flush       = 1'b0;
        new_pc      = '0;
        ext_exc     = (excepttype_i != 32'h0);
        wd_fire     = 1'b0;
        code        = excepttype_i;

        case (state_q)
            RUN: begin
                wd_fire = (WDOG_LIM != 0) && !ext_exc && (|stallreq_i) &&
                          (wd_cnt_q == WDW'(WDOG_LIM));
                if (ext_exc || wd_fire) begin
                    code        = ext_exc ? excepttype_i : TIMEOUT_CODE;
                    flush       = 1'b1;
                    new_pc      = exc_target(code, cp0_epc_i);
                    pc_d        = new_pc;
                    exc_code_d  = code;
                    timeout_d   = wd_fire;
                    wd_cnt_d    = '0;
                    if (flush_cnt_q != '1) flush_cnt_d = flush_cnt_q + 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_d = FLUSH;
                        fcnt_d  = FCW'(FLUSH_CYC - 1);
                    end
                end else begin
                    stall = therm;
                    if ((WDOG_LIM != 0) && (|therm)) wd_cnt_d = wd_cnt_q + 1'b1;
                    else                             wd_cnt_d = '0;
                end
            end
            FLUSH: begin
                flush    = 1'b1;
                new_pc   = pc_q;
                wd_cnt_d = '0;
                fcnt_d   = fcnt_q - 1'b1;
                if (fcnt_q == FCW'(1)) state_d = RUN;
            end
            default: state_d = RUN;
        endcase

        if (!rst_n) begin
            stall  = '0;
            flush  = 1'b0;
            new_pc = '0;
        end

        stall_cnt_d = stall_cnt_q;
        if ((stall != '0) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // NOTE: state uses non-blocking assignments and a synchronous reset sampled only on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            fcnt_q      <= '0;
            pc_q        <= '0;
            exc_code_q  <= '0;
            timeout_q   <= 1'b0;
            wd_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pc_q        <= pc_d;
            exc_code_q  <= exc_code_d;
            timeout_q   <= timeout_d;
            wd_cnt_q    <= wd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_o     = stall;
    assign flush_o     = flush;
    assign new_pc_o    = new_pc;
    assign exc_code_o  = exc_code_q;
    assign timeout_o   = timeout_q;
    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl_n.sv
// Directed scoreboard bench for pipe_ctrl_n: three instances cover the single-cycle flush with a
// short watchdog, a multi-cycle flush with 2-bit saturating counters, and reset during a flush.
module tb_pipe_ctrl_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn [3];
    logic [5:0]  sreq [3];
    logic [31:0] exc  [3];
    logic [31:0] epc  [3];

    logic [5:0]  a_stall, b_stall, c_stall;
    logic        a_flush, b_flush, c_flush;
    logic [31:0] a_pc, b_pc, c_pc;
    logic [31:0] a_code, b_code, c_code;
    logic        a_to, b_to, c_to;
    logic [31:0] a_scnt, a_fcnt, c_scnt, c_fcnt;
    logic [1:0]  b_scnt, b_fcnt;

    pipe_ctrl_n #(.WDOG_LIM(4)) u_a (
        .clk(clk), .rst_n(rstn[0]), .stallreq_i(sreq[0]), .excepttype_i(exc[0]), .cp0_epc_i(epc[0]),
        .stall_o(a_stall), .flush_o(a_flush), .new_pc_o(a_pc), .exc_code_o(a_code),
        .timeout_o(a_to), .stall_cnt_o(a_scnt), .flush_cnt_o(a_fcnt));

    pipe_ctrl_n #(.FLUSH_CYC(3), .WDOG_LIM(0), .CNTW(2)) u_b (
        .clk(clk), .rst_n(rstn[1]), .stallreq_i(sreq[1]), .excepttype_i(exc[1]), .cp0_epc_i(epc[1]),
        .stall_o(b_stall), .flush_o(b_flush), .new_pc_o(b_pc), .exc_code_o(b_code),
        .timeout_o(b_to), .stall_cnt_o(b_scnt), .flush_cnt_o(b_fcnt));

    pipe_ctrl_n #(.FLUSH_CYC(4)) u_c (
        .clk(clk), .rst_n(rstn[2]), .stallreq_i(sreq[2]), .excepttype_i(exc[2]), .cp0_epc_i(epc[2]),
        .stall_o(c_stall), .flush_o(c_flush), .new_pc_o(c_pc), .exc_code_o(c_code),
        .timeout_o(c_to), .stall_cnt_o(c_scnt), .flush_cnt_o(c_fcnt));

    typedef struct {
        int          inst;
        string       name;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] code;
        logic        to;
        logic [31:0] scnt;
        logic [31:0] fcnt;
    } obs_t;

    obs_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Inputs change just after the rising edge; the instance not under test idles.
    task automatic drive(input int inst, input logic rst, input logic [5:0] s,
                         input logic [31:0] x, input logic [31:0] p);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            sreq[i] = '0;
            exc[i]  = '0;
            epc[i]  = '0;
        end
        rstn[inst] = rst;
        sreq[inst] = s;
        exc[inst]  = x;
        epc[inst]  = p;
    endtask

    task automatic vec(input int inst, input string name, input logic rst, input logic [5:0] s,
                       input logic [31:0] x, input logic [31:0] p,
                       input logic [5:0] e_stall, input logic e_flush, input logic [31:0] e_pc,
                       input logic [31:0] e_code, input logic e_to,
                       input logic [31:0] e_scnt, input logic [31:0] e_fcnt);
        obs_t e;
        drive(inst, rst, s, x, p);
        e.inst = inst;  e.name = name;  e.stall = e_stall;  e.flush = e_flush;  e.pc = e_pc;
        e.code = e_code;  e.to = e_to;  e.scnt = e_scnt;  e.fcnt = e_fcnt;
        sb.push_back(e);
    endtask

    // Monitor: sample mid-cycle and compare against the oldest expectation.
    always @(negedge clk) begin
        if (sb.size() != 0) begin
            obs_t e;
            obs_t g;
            e = sb.pop_front();
            g.inst = e.inst;
            g.name = e.name;
            case (e.inst)
                0: begin
                    g.stall = a_stall; g.flush = a_flush; g.pc = a_pc; g.code = a_code;
                    g.to = a_to; g.scnt = a_scnt; g.fcnt = a_fcnt;
                end
                1: begin
                    g.stall = b_stall; g.flush = b_flush; g.pc = b_pc; g.code = b_code;
                    g.to = b_to; g.scnt = {30'b0, b_scnt}; g.fcnt = {30'b0, b_fcnt};
                end
                default: begin
                    g.stall = c_stall; g.flush = c_flush; g.pc = c_pc; g.code = c_code;
                    g.to = c_to; g.scnt = c_scnt; g.fcnt = c_fcnt;
                end
            endcase
            n_vec++;
            if (g.stall !== e.stall || g.flush !== e.flush || g.pc !== e.pc || g.code !== e.code ||
                g.to !== e.to || g.scnt !== e.scnt || g.fcnt !== e.fcnt) begin
                n_miss++;
                $display("FAIL %s: got stall=%b flush=%b pc=%h code=%h to=%b scnt=%0d fcnt=%0d; want stall=%b flush=%b pc=%h code=%h to=%b scnt=%0d fcnt=%0d",
                         e.name, g.stall, g.flush, g.pc, g.code, g.to, g.scnt, g.fcnt,
                         e.stall, e.flush, e.pc, e.code, e.to, e.scnt, e.fcnt);
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            rstn[i] = 1'b0;
            sreq[i] = '0;
            exc[i]  = '0;
            epc[i]  = '0;
        end

        // Instance A: FLUSH_CYC=1, WDOG_LIM=4.
        vec(0, "a_rst",        0, 6'b000100, 'h08, 0,      6'b000000, 0, 'h0,    'h00, 0, 0, 0);
        vec(0, "a_idle",       1, 6'b000000, 'h00, 0,      6'b000000, 0, 'h0,    'h00, 0, 0, 0);
        vec(0, "a_stall_b2",   1, 6'b000100, 'h00, 0,      6'b000111, 0, 'h0,    'h00, 0, 0, 0);
        vec(0, "a_stall_b4",   1, 6'b010100, 'h00, 0,      6'b011111, 0, 'h0,    'h00, 0, 1, 0);
        vec(0, "a_stall_b3",   1, 6'b001000, 'h00, 0,      6'b001111, 0, 'h0,    'h00, 0, 2, 0);
        vec(0, "a_exc08",      1, 6'b001000, 'h08, 0,      6'b000000, 1, 'h40,   'h00, 0, 3, 0);
        vec(0, "a_post08",     1, 6'b000000, 'h00, 0,      6'b000000, 0, 'h0,    'h08, 0, 3, 1);
        vec(0, "a_eret",       1, 6'b000000, 'h0e, 'h1234, 6'b000000, 1, 'h1234, 'h08, 0, 3, 1);
        vec(0, "a_int",        1, 6'b000000, 'h01, 'h1234, 6'b000000, 1, 'h20,   'h0e, 0, 3, 2);
        vec(0, "a_exc0a",      1, 6'b000000, 'h0a, 0,      6'b000000, 1, 'h40,   'h01, 0, 3, 3);
        vec(0, "a_exc_other",  1, 6'b000000, 'h33, 0,      6'b000000, 1, 'h40,   'h0a, 0, 3, 4);
        vec(0, "a_quiet",      1, 6'b000000, 'h00, 0,      6'b000000, 0, 'h0,    'h33, 0, 3, 5);
        for (int i = 0; i < 4; i++)
            vec(0, "a_wd_stall", 1, 6'b001000, 'h00, 0,    6'b001111, 0, 'h0,    'h33, 0, 3 + i, 5);
        vec(0, "a_wd_fire",    1, 6'b001000, 'h00, 0,      6'b000000, 1, 'h40,   'h33, 0, 7, 5);
        vec(0, "a_wd_pulse",   1, 6'b001000, 'h00, 0,      6'b001111, 0, 'h0,    'h10, 1, 7, 6);
        for (int i = 0; i < 3; i++)
            vec(0, "a_wd_restart", 1, 6'b001000, 'h00, 0,  6'b001111, 0, 'h0,    'h10, 0, 8 + i, 6);
        vec(0, "a_ext_over_wd", 1, 6'b001000, 'h0d, 0,     6'b000000, 1, 'h40,   'h10, 0, 11, 6);
        vec(0, "a_no_timeout", 1, 6'b000000, 'h00, 0,      6'b000000, 0, 'h0,    'h0d, 0, 11, 7);

        // Instance B: FLUSH_CYC=3, watchdog off, 2-bit counters.
        vec(1, "b_idle",       1, 6'b000000, 'h00, 0,      6'b000000, 0, 'h0,    'h00, 0, 0, 0);
        vec(1, "b_flush_1",    1, 6'b000010, 'h0c, 0,      6'b000000, 1, 'h40,   'h00, 0, 0, 0);
        vec(1, "b_flush_2",    1, 6'b000010, 'h0c, 0,      6'b000000, 1, 'h40,   'h0c, 0, 0, 1);
        vec(1, "b_flush_3",    1, 6'b000010, 'h0c, 0,      6'b000000, 1, 'h40,   'h0c, 0, 0, 1);
        vec(1, "b_run",        1, 6'b000010, 'h00, 0,      6'b000011, 0, 'h0,    'h0c, 0, 0, 1);
        vec(1, "b_eret",       1, 6'b000000, 'h0e, 'h100,  6'b000000, 1, 'h100,  'h0c, 0, 1, 1);
        vec(1, "b_ignore_exc", 1, 6'b000000, 'h01, 'h200,  6'b000000, 1, 'h100,  'h0e, 0, 1, 2);
        vec(1, "b_ignore_stall", 1, 6'b111111, 'h00, 'h300, 6'b000000, 1, 'h100, 'h0e, 0, 1, 2);
        vec(1, "b_back",       1, 6'b000000, 'h00, 0,      6'b000000, 0, 'h0,    'h0e, 0, 1, 2);
        for (int i = 0; i < 3; i++)
            vec(1, "b_sat_stall", 1, 6'b000001, 'h00, 0,   6'b000001, 0, 'h0,    'h0e, 0, 1 + i, 2);
        vec(1, "b_sat_hold",   1, 6'b100000, 'h00, 0,      6'b111111, 0, 'h0,    'h0e, 0, 3, 2);
        vec(1, "b_exc_sat",    1, 6'b000000, 'h0a, 0,      6'b000000, 1, 'h40,   'h0e, 0, 3, 2);
        for (int i = 0; i < 2; i++)
            vec(1, "b_exc_sat_fl", 1, 6'b000000, 'h00, 0,  6'b000000, 1, 'h40,   'h0a, 0, 3, 3);
        vec(1, "b_fcnt_hold",  1, 6'b000000, 'h01, 0,      6'b000000, 1, 'h20,   'h0a, 0, 3, 3);
        for (int i = 0; i < 2; i++)
            vec(1, "b_fcnt_hold_fl", 1, 6'b000000, 'h00, 0, 6'b000000, 1, 'h20,  'h01, 0, 3, 3);
        vec(1, "b_end",        1, 6'b000000, 'h00, 0,      6'b000000, 0, 'h0,    'h01, 0, 3, 3);

        // Instance C: FLUSH_CYC=4, reset lands on the second flush cycle.
        vec(2, "c_idle",       1, 6'b000000, 'h00, 0,      6'b000000, 0, 'h0,    'h00, 0, 0, 0);
        vec(2, "c_exc08",      1, 6'b000000, 'h08, 0,      6'b000000, 1, 'h40,   'h00, 0, 0, 0);
        drive(2, 0, 6'b000000, 'h00, 0);
        vec(2, "c_after_rst",  1, 6'b000000, 'h00, 0,      6'b000000, 0, 'h0,    'h00, 0, 0, 0);
        vec(2, "c_stall",      1, 6'b000100, 'h00, 0,      6'b000111, 0, 'h0,    'h00, 0, 0, 0);
        vec(2, "c_stall_cnt",  1, 6'b000000, 'h00, 0,      6'b000000, 0, 'h0,    'h00, 0, 1, 0);

        for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl_n.md
Name: pipe_ctrl_n

Overview:
Parametrised pipeline controller for the tinyMIPS core family. It generates the per-stage stall vector from an arbitrary number of stage stall requests and redirects the PC on exceptions and ERET. Flush is held for a programmable number of cycles, and a stall watchdog forces a timeout exception when stalls run too long. It also provides saturating stall and flush performance counters. It sits beside the pipeline registers and drives their stall/flush inputs and the PC-redirect mux.

Parameters:
NSTAGE, 6, number of pipeline register stages; stall vector width (bit 0 = PC, ascending toward WB).
AW, 32, address width of PC/EPC.
IBASE, 32'h00000020, interrupt vector.
EBASE, 32'h00000040, general exception vector.
FLUSH_CYC, 1, cycles flush_o is held per exception (>=1).
WDOG_LIM, 255, consecutive stalled cycles that trigger a timeout exception (0 disables the watchdog).
CNTW, 32, performance counter width.

Ports:
clk  in  1  clock.
rst_n  in  1  reset.
stallreq_i  in  NSTAGE  bit s = stage s requests stall.
excepttype_i  in  32  exception code from MEM; 0 = none.
cp0_epc_i  in  AW  EPC for ERET.
stall_o  out  NSTAGE  stall vector.
flush_o  out  1  flush all pipeline registers.
new_pc_o  out  AW  redirect target, valid while flush_o=1.
exc_code_o  out  32  code of the last exception taken (registered).
timeout_o  out  1  one-cycle pulse when the watchdog fires.
stall_cnt_o  out  CNTW  total stalled cycles, saturating.
flush_cnt_o  out  CNTW  total exceptions taken, saturating.

Behaviour:
- Reset: rst_n, synchronous, active-low. All outputs are 0, the FSM is in RUN, and the watchdog count is 0.
- Stall vector (combinational, RUN only): let h = highest set index in stallreq_i; stall_o[h:0]=1 and the upper bits are 0. If no request is set, stall_o=0.
  - Examples: a request at bit 2 gives 000111; at bit 3 gives 001111; at bit 4 gives 011111.
  - stall_o=0 whenever flush_o=1 or rst_n=0.
- Exception target decode:
  - 0x01 -> IBASE.
  - 0x08, 0x0a, 0x0c, 0x0d -> EBASE.
  - 0x0e -> cp0_epc_i.
  - Any other nonzero code -> EBASE.
  - Internal timeout code 0x10 -> EBASE.
- FSM states: RUN and FLUSH.
  - RUN, excepttype_i != 0:
    - Same cycle: flush_o=1, new_pc_o=target (combinational), stall_o=0.
    - At the clock edge: exc_code_o <= code, flush_cnt++, and new_pc is latched.
    - If FLUSH_CYC>1, go to FLUSH with remaining count FLUSH_CYC-1; otherwise stay in RUN.
  - FLUSH:
    - flush_o=1, new_pc_o = latched target, stall_o=0.
    - excepttype_i and stallreq_i are ignored.
    - Count decrements each cycle; return to RUN after the cycle in which it reaches 0.
  - RUN, no exception: flush_o=0 and new_pc_o=0.
- Priority in RUN: external exception > watchdog timeout > stall.
- Watchdog (WDOG_LIM>0):
  - wd_cnt increments on each RUN cycle with stall_o != 0 and clears on any cycle with stall_o=0 or flush_o=1.
  - When wd_cnt==WDOG_LIM and a stall is still requested with no external exception, the controller takes a timeout exception that cycle:
    - code 0x10 is treated exactly like an external exception;
    - timeout_o=1 for that one cycle (registered pulse, visible the next cycle);
    - wd_cnt clears.
  - An external exception in the same cycle wins; no timeout is taken and wd_cnt clears.
- Counters:
  - stall_cnt increments on each cycle with stall_o != 0.
  - flush_cnt increments once per exception taken, not once per flush cycle.
  - Both hold at all-ones and never wrap.
- Reset asserted mid-FLUSH aborts the flush; the next cycle is in RUN with all outputs 0.

Test Plan:
1. stallreq_i=6'b000100 for 1 cycle -> stall_o=6'b000111, flush_o=0; stallreq_i=6'b010100 -> stall_o=6'b011111; stall_cnt_o increments by 1 per cycle.
2. excepttype_i=0x08 while stallreq_i=6'b001000 -> same cycle flush_o=1, stall_o=0, new_pc_o=0x40; next cycle exc_code_o=0x08, flush_cnt_o=1.
3. excepttype_i=0x0e, cp0_epc_i=0x00001234 -> new_pc_o=0x1234 with flush_o=1; excepttype_i=0x01 -> new_pc_o=0x20.
4. FLUSH_CYC=3, excepttype_i=0x0c held for 3 cycles -> flush_o=1 for exactly 3 cycles, flush_cnt_o=+1 only, new_pc_o=0x40 throughout, stall_o=0.
5. WDOG_LIM=4, stallreq_i=6'b001000 held -> stall_o=001111 for 4 cycles, then flush_o=1, new_pc_o=0x40, timeout_o pulses once, exc_code_o=0x10; wd_cnt restarts.
6. FLUSH_CYC=4, rst_n=0 during the 2nd flush cycle -> next cycle all outputs 0 and counters 0; afterwards stallreq_i=6'b000100 gives stall_o=000111 normally.
